// File: rtl/processador_multiciclo_param_if.sv
// Fetch/execute bus of the multicycle core: instruction/immediate input, bus and step observation.
interface processador_multiciclo_param_if #(
    parameter int DATA_W = 16
);
    logic              Run;
    logic [DATA_W-1:0] DIN;
    logic              Done;
    logic [DATA_W-1:0] BusWires;
    logic [1:0]        Tstep;

    modport master (output Run, DIN, input Done, BusWires, Tstep);
    modport slave  (input Run, DIN, output Done, BusWires, Tstep);
endinterface

// File: rtl/processador_multiciclo_param.sv
// Parametrised multicycle core: mv/mvi/mvnz/nop in 2 steps, add/sub/and/xor in 4 steps over one shared bus.
module processador_multiciclo_param #(
    parameter int DATA_W   = 16,
    parameter int REG_BITS = 3
) (
    input  logic                           Clock,
    input  logic                           Reset,
    processador_multiciclo_param_if.slave  bus_if
);
    localparam int NREGS = 2**REG_BITS;
    localparam int IRW   = 3 + 2*REG_BITS;

    typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_e;
    typedef enum logic [2:0] {
        OP_MV  = 3'b000, OP_MVI = 3'b001, OP_ADD  = 3'b010, OP_SUB = 3'b011,
        OP_AND = 3'b100, OP_XOR = 3'b101, OP_MVNZ = 3'b110, OP_NOP = 3'b111
    } op_e;

    step_e                          step_q;
    logic [IRW-1:0]                 ir_q;
    logic [NREGS-1:0][DATA_W-1:0]   r_q;
    logic [DATA_W-1:0]              a_q, g_q;

    op_e                 op;
    logic [REG_BITS-1:0] rx, ry;
    logic                z;
    logic [DATA_W-1:0]   bus, alu;
    logic                done;

    assign op = op_e'(ir_q[IRW-1 -: 3]);
    assign rx = ir_q[IRW-4 -: REG_BITS];
    assign ry = ir_q[REG_BITS-1:0];
    assign z  = (g_q == '0);

    always_comb begin
        bus  = '0;
        done = 1'b0;
        unique case (step_q)
            T0: bus = bus_if.DIN;
            T1: begin
                unique case (op)
                    OP_MV, OP_MVNZ: begin bus = r_q[ry];     done = 1'b1; end
                    OP_MVI:         begin bus = bus_if.DIN; done = 1'b1; end
                    OP_NOP:         begin bus = '0;         done = 1'b1; end
                    default:        bus = r_q[rx];
                endcase
            end
            T2: bus = r_q[ry];
            T3: begin bus = g_q; done = 1'b1; end
        endcase
    end

    // sub is two's-complement add so the result wraps exactly like add
    always_comb begin
        alu = '0;
        unique case (op)
            OP_ADD:  alu = a_q + bus;
            OP_SUB:  alu = a_q + ~bus + {{(DATA_W-1){1'b0}}, 1'b1};
            OP_AND:  alu = a_q & bus;
            OP_XOR:  alu = a_q ^ bus;
            default: alu = '0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            step_q <= T0;
            ir_q   <= '0;
            r_q    <= '0;
            a_q    <= '0;
            g_q    <= '0;
        end else begin
            unique case (step_q)
                T0: if (bus_if.Run) begin
                    ir_q   <= bus_if.DIN[IRW-1:0];
                    step_q <= T1;
                end
                T1: begin
                    unique case (op)
                        OP_MV, OP_MVI: begin r_q[rx] <= bus; step_q <= T0; end
                        OP_MVNZ: begin
                            if (!z) r_q[rx] <= bus;
                            step_q <= T0;
                        end
                        OP_NOP:  step_q <= T0;
                        default: begin a_q <= bus; step_q <= T2; end
                    endcase
                end
                T2: begin g_q <= alu; step_q <= T3; end
                T3: begin r_q[rx] <= g_q; step_q <= T0; end
            endcase
        end
    end

    assign bus_if.Done     = done;
    assign bus_if.BusWires = bus;
    assign bus_if.Tstep    = step_q;
endmodule
